// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side drain stage for sync_fifo.
//
// Pops words from the FIFO using its empty flag and captures the combinational
// dout in the same cycle as rd_en. The words are re-emitted on a valid/ready
// stream in bursts of BURST_LEN beats, with m_last on the final beat. If the
// FIFO stays empty for TIMEOUT cycles, a partial burst is closed so trailing
// words never stall.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   fifo_dout   FIFO read data, valid only while fifo_rd_en=1
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO pop strobe (combinational, depends on m_ready)
//   m_data      stream data (registered)
//   m_valid     stream valid (registered)
//   m_last      last beat of burst (registered)
//   m_ready     downstream accept
//   burst_cnt   bursts completed (beats accepted with m_last), wraps at 2^16
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [15:0]           burst_cnt
);

  localparam int unsigned PosW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PosW-1:0]  PosLast = PosW'(BURST_LEN - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT - 1);

  // HOLD stage
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [PosW-1:0]       hold_idx_q, hold_idx_d;
  // OUT stage
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  // Bookkeeping
  logic [PosW-1:0]       burst_pos_q, burst_pos_d;
  logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;

  logic out_free;
  logic hold_closed;
  logic pop;
  logic xfer_closed;
  logic xfer_pop;
  logic xfer_flush;
  logic xfer;

  always_comb begin
    out_free    = !m_valid_q || m_ready;
    hold_closed = (hold_idx_q == PosLast);
    // A full HOLD can only accept a new word if it drains into OUT this cycle,
    // which is why m_ready reaches fifo_rd_en combinationally.
    pop         = !reset && !fifo_empty && (!hold_vld_q || out_free);

    xfer_closed = hold_vld_q && out_free && hold_closed;
    xfer_pop    = hold_vld_q && out_free && !hold_closed && pop;
    // A pop always wins over the flush; pop implies !fifo_empty anyway.
    xfer_flush  = hold_vld_q && out_free && !hold_closed && !pop && fifo_empty &&
                  (idle_cnt_q == IdleMax);
    xfer        = xfer_closed || xfer_pop || xfer_flush;
  end

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_idx_d  = hold_idx_q;
    burst_pos_d = burst_pos_q;
    idle_cnt_d  = '0;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    burst_cnt_d = burst_cnt_q;

    if (pop) begin
      hold_vld_d  = 1'b1;
      hold_data_d = fifo_dout;
      hold_idx_d  = burst_pos_q;
      burst_pos_d = (burst_pos_q == PosLast) ? '0 : burst_pos_q + 1'b1;
    end else if (xfer) begin
      hold_vld_d = 1'b0;
    end

    // Flush never coincides with a pop, so the restart cannot race the advance.
    if (xfer_flush) begin
      burst_pos_d = '0;
    end

    // Only an open word waiting on an empty FIFO ages toward the timeout.
    if (hold_vld_q && !hold_closed && fifo_empty) begin
      idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end

    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = hold_data_q;
      m_last_d  = xfer_closed || xfer_flush;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

    if (m_valid_q && m_ready && m_last_q) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_idx_q  <= '0;
      burst_pos_q <= '0;
      idle_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_idx_q  <= hold_idx_d;
      burst_pos_q <= burst_pos_d;
      idle_cnt_q  <= idle_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign burst_cnt  = burst_cnt_q;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain stage placed directly downstream of the team's synchronous FIFO (`sync_fifo`). It pops words using the FIFO's `empty` flag, captures the combinational `dout` in the same cycle as `rd_en`, and re-emits the words on a valid/ready stream grouped into bursts of `BURST_LEN` beats with `m_last` marking the final beat. A partial burst is closed by an idle timeout, so trailing words never stall.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `BURST_LEN`, default 4: beats per full burst; valid range is 1 or more.
- `TIMEOUT`, default 16: empty-FIFO cycles before a partial burst is closed; valid range is 1 or more.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `fifo_dout`  in  `DATA_WIDTH`: FIFO read data. It is valid only in a cycle where `fifo_rd_en`=1, and is 0 otherwise.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO pop strobe, combinational.
- `m_data`  out  `DATA_WIDTH`: stream data, registered.
- `m_valid`  out  1: stream valid, registered.
- `m_last`  out  1: final beat of a burst, registered.
- `m_ready`  in  1: downstream accept.
- `burst_cnt`  out  16: count of bursts completed, i.e. beats accepted with `m_last`=1. Wraps modulo 2^16.

## Operation
- **Internal storage.**
  - Two registered stages:
    - HOLD: `hold_vld`, `hold_data`, `hold_idx`.
    - OUT: `m_valid`, `m_data`, `m_last`.
  - `burst_pos` is the index to assign to the next popped word.
  - `idle_cnt` saturates at `TIMEOUT-1`.
- **Derived signals.**
  - `out_free = !m_valid || m_ready`.
  - A HOLD word is *closed* when `hold_idx == BURST_LEN-1`.
- **Pop rule (`fifo_rd_en`).**
  - 0 while `reset`=1 or `fifo_empty`=1.
  - Otherwise 1 if `hold_vld`=0.
  - Otherwise 1 if `out_free`=1, whether HOLD is closed or not.
  - There is a combinational path from `m_ready` to `fifo_rd_en`. This is intentional.
- **On a pop.**
  - `hold_data <= fifo_dout`.
  - `hold_idx <= burst_pos`.
  - `burst_pos` advances modulo `BURST_LEN`.
- **HOLD to OUT transfer.** Occurs only when `hold_vld`=1 and `out_free`=1, on one of:
  - (a) HOLD is closed: `m_last <= 1`.
  - (b) A pop happens in the same cycle: `m_last <= 0`.
  - (c) `fifo_empty`=1 and `idle_cnt == TIMEOUT-1`: this is a timeout flush. `m_last <= 1` and `burst_pos <= 0`.
- **Transfer priority.** (a) is evaluated on the HOLD word itself. Between (b) and (c), a pop always wins.
- **`idle_cnt` update.**
  - Increments in cycles where `hold_vld`=1, HOLD is not closed, and `fifo_empty`=1.
  - Clears in all other cycles.
- **OUT stage.**
  - If there is no transfer and `m_ready`=1, then `m_valid <= 0`.
  - `m_data` and `m_last` stay stable while `m_valid && !m_ready`.
- **`burst_cnt`** increments on each cycle with `m_valid && m_ready && m_last`.
- **Ordering and loss.** Word order is preserved. No word is dropped or duplicated under any `m_ready` pattern.
- **`BURST_LEN`=1.** Every word is closed and every beat has `m_last`=1. `idle_cnt` never counts.
- **Reset** (including mid-burst):
  - `hold_vld`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
  - `burst_pos`=0, `idle_cnt`=0, `burst_cnt`=0.
  - `fifo_rd_en`=0.
  - Words held in HOLD or OUT are discarded. The FIFO is reset by its own logic.

## Timing
- **Pop capture.** A pop in cycle N makes `hold_vld`=1 from cycle N+1.
- **Closed word latency.** With `out_free`=1, the closed word is presented (`m_valid`=1) in cycle N+2.
- **Non-closed word latency.** The word is presented in the cycle after the next pop.
- **Timeout flush latency.** Single word popped in cycle 0, FIFO then empty, `m_ready`=1:
  - `idle_cnt` = 0 in cycle 1 and reaches `TIMEOUT-1` in cycle `TIMEOUT`.
  - `m_valid`=`m_last`=1 in cycle `TIMEOUT+1` (cycle 17 for defaults).
- **Throughput.** Sustained at 1 beat/cycle when the FIFO is non-empty and `m_ready`=1.
- **Backpressure.** With `m_ready`=0 and both stages full, `fifo_rd_en`=0.
- **Saturated timeout under backpressure.** If `idle_cnt` is saturated while OUT is blocked:
  - The flush occurs in the first cycle with `out_free`=1.
  - If the FIFO is non-empty in that cycle, a normal transfer (b) occurs instead.

## Test plan
- **Reset values.** Assert `reset` for 3 cycles with `fifo_empty`=0 -> `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `burst_cnt`=0 throughout.
- **Full bursts.** Defaults; FIFO supplies 0x01..0x08 back-to-back; `m_ready`=1 -> 8 beats in order, `m_last`=1 on 0x04 and 0x08 only, `burst_cnt`=2.
- **Single-word timeout.** One word 0xA5 popped in cycle 0, then FIFO empty -> `m_valid`=`m_last`=1 with `m_data`=0xA5 first in cycle 17; `burst_cnt`=1 after acceptance.
- **Partial burst, then restart.** Push 0x10..0x12, gap of 20 cycles, push 0x20..0x23:
  - 0x12 carries `m_last` via timeout.
  - 0x23 carries `m_last` (new burst indexed from 0).
  - `burst_cnt`=2.
- **Backpressure.** 8 words with `m_ready`=0 for cycles 3..12:
  - `fifo_rd_en`=0 once both stages are full.
  - `m_data` stable while stalled.
  - All 8 words delivered in order after release, with `m_last` on beats 4 and 8.
- **Reset mid-burst.** Assert `reset` for 1 cycle after 2 beats of a burst are accepted -> all outputs return to reset values. After a fresh FIFO fill of 4 words, `m_last` falls on the 4th new word.
